// File: rtl/pixel_packer_pkg.sv
// Shared constants for the pixel pipeline.
//   LANE_W   : width of one pixel byte lane
//   WORD_W   : width of a packed output word
//   LANES    : pixel lanes per word
//   LAST_BIT : position of the end-of-frame flag in a FIFO entry
//   ENTRY_W  : FIFO entry width ({last, word})
package pixel_packer_pkg;
  localparam int unsigned LANE_W   = 8;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LANES    = WORD_W / LANE_W;
  localparam int unsigned LAST_BIT = WORD_W;
  localparam int unsigned ENTRY_W  = WORD_W + 1;

  typedef logic [$clog2(LANES)-1:0] lane_t;
endpackage

// File: rtl/pack_fifo.sv
// Single-clock FIFO used to buffer packed words.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear of pointers and occupancy
//   push      : write wr_data (ignored when full)
//   pop       : drop head entry (ignored when empty)
//   rd_data   : head entry, combinational
//   full/empty: occupancy flags
module pack_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pixel_packer.sv
// Packs a byte-wide pixel stream into 32-bit words, first pixel in the low
// lane, and buffers the words in a FIFO with an end-of-frame flag.
//   clk, rstn    : clock, asynchronous active-low reset
//   pix_in/pix_valid/pix_ready    : pixel input handshake
//   soft_clr     : synchronous clear of frame state and FIFO
//   word_out/word_last/word_valid/word_ready : packed word output handshake
//   frame_done   : one-cycle pulse after the final pixel of a frame
//   pix_count    : pixels accepted in the current frame
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 1024,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [LANE_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              soft_clr,
  output logic [WORD_W-1:0] word_out,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_done,
  output logic [15:0]       pix_count
);
  lane_t              lane;
  logic [WORD_W-1:0]  part_word;
  logic [WORD_W-1:0]  next_word;
  logic               rdy_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               last_pix;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  // rdy_en holds pix_ready low during reset and releases it one edge later.
  assign pix_ready = rdy_en & ~fifo_full & ~soft_clr;
  assign accept    = pix_valid & pix_ready;
  assign last_pix  = (pix_count == 16'(FRAME_PIXELS - 1));
  assign push      = accept & ((lane == lane_t'(LANES - 1)) | last_pix);

  always_comb begin
    next_word = part_word;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane == lane_t'(k)) next_word[k*LANE_W +: LANE_W] = pix_in;
    end
  end

  // Upper lanes of a short final word are zero since part_word is cleared
  // after every push.
  always_comb begin
    push_data           = {1'b0, next_word};
    push_data[LAST_BIT] = last_pix;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en     <= 1'b0;
      lane       <= '0;
      part_word  <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      frame_done <= accept & last_pix;
      if (soft_clr) begin
        lane      <= '0;
        part_word <= '0;
        pix_count <= '0;
      end else if (accept) begin
        if (last_pix) begin
          lane      <= '0;
          part_word <= '0;
          pix_count <= '0;
        end else begin
          lane      <= lane + lane_t'(1);
          part_word <= push ? '0 : next_word;
          pix_count <= pix_count + 16'd1;
        end
      end
    end
  end

  pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (soft_clr),
    .push    (push),
    .wr_data (push_data),
    .pop     (word_valid & word_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The head RAM is not reset, so mask it while the FIFO is empty.
  assign word_valid = ~fifo_empty;
  assign word_out   = word_valid ? head[WORD_W-1:0] : '0;
  assign word_last  = word_valid & head[LAST_BIT];
endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;
  logic clk;
  logic rstn;

  logic [7:0]  a_pix_in, b_pix_in;
  logic        a_pix_valid, b_pix_valid;
  logic        a_pix_ready, b_pix_ready;
  logic        a_soft_clr, b_soft_clr;
  logic [31:0] a_word_out, b_word_out;
  logic        a_word_last, b_word_last;
  logic        a_word_valid, b_word_valid;
  logic        a_word_ready, b_word_ready;
  logic        a_frame_done, b_frame_done;
  logic [15:0] a_pix_count, b_pix_count;

  int errors = 0;
  int checks = 0;

  pixel_packer #(.FRAME_PIXELS(8), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .rstn(rstn), .pix_in(a_pix_in), .pix_valid(a_pix_valid),
    .pix_ready(a_pix_ready), .soft_clr(a_soft_clr), .word_out(a_word_out),
    .word_last(a_word_last), .word_valid(a_word_valid), .word_ready(a_word_ready),
    .frame_done(a_frame_done), .pix_count(a_pix_count)
  );

  pixel_packer #(.FRAME_PIXELS(6), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rstn(rstn), .pix_in(b_pix_in), .pix_valid(b_pix_valid),
    .pix_ready(b_pix_ready), .soft_clr(b_soft_clr), .word_out(b_word_out),
    .word_last(b_word_last), .word_valid(b_word_valid), .word_ready(b_word_ready),
    .frame_done(b_frame_done), .pix_count(b_pix_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [7:0]  pix;
    logic        wr;
    logic        clr;
    logic        e_rdy;
    logic        e_wv;
    logic [31:0] e_wo;
    logic        e_wl;
    logic        e_fd;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(logic v, logic [7:0] pix, logic wr, logic clr,
                              logic e_rdy, logic e_wv, logic [31:0] e_wo,
                              logic e_wl, logic e_fd, logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.pix = pix; r.wr = wr; r.clr = clr;
    r.e_rdy = e_rdy; r.e_wv = e_wv; r.e_wo = e_wo;
    r.e_wl = e_wl; r.e_fd = e_fd; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic a_idle(input logic wr);
    a_pix_valid  = 1'b0;
    a_pix_in     = 8'h00;
    a_soft_clr   = 1'b0;
    a_word_ready = wr;
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    a_idle(1'b0);
    rstn = 1'b0;
    #1;
    chk("rst_pix_ready",  32'(a_pix_ready),  32'd0);
    chk("rst_word_valid", 32'(a_word_valid), 32'd0);
    chk("rst_word_out",   a_word_out,        32'd0);
    chk("rst_word_last",  32'(a_word_last),  32'd0);
    chk("rst_frame_done", 32'(a_frame_done), 32'd0);
    chk("rst_pix_count",  32'(a_pix_count),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic a_feed(input logic [7:0] pix, input logic wr);
    @(negedge clk);
    a_pix_valid  = 1'b1;
    a_pix_in     = pix;
    a_word_ready = wr;
    a_soft_clr   = 1'b0;
  endtask

  logic [32:0] got_q[$];
  int          next_idx;
  int          fd_cnt;

  initial begin
    rstn = 1'b0;
    a_idle(1'b0);
    b_pix_valid = 1'b0; b_pix_in = 8'h00; b_soft_clr = 1'b0; b_word_ready = 1'b0;

    tbl[0]  = mk(1, 8'h01, 1, 0, 1, 0, 32'h0,        0, 0, 16'd0);
    tbl[1]  = mk(1, 8'h02, 1, 0, 1, 0, 32'h0,        0, 0, 16'd1);
    tbl[2]  = mk(1, 8'h03, 1, 0, 1, 0, 32'h0,        0, 0, 16'd2);
    tbl[3]  = mk(1, 8'h04, 1, 0, 1, 0, 32'h0,        0, 0, 16'd3);
    tbl[4]  = mk(1, 8'h05, 1, 0, 1, 1, 32'h04030201, 0, 0, 16'd4);
    tbl[5]  = mk(1, 8'h06, 1, 0, 1, 0, 32'h0,        0, 0, 16'd5);
    tbl[6]  = mk(1, 8'h07, 1, 0, 1, 0, 32'h0,        0, 0, 16'd6);
    tbl[7]  = mk(1, 8'h08, 1, 0, 1, 0, 32'h0,        0, 0, 16'd7);
    tbl[8]  = mk(0, 8'h00, 1, 0, 1, 1, 32'h08070605, 1, 1, 16'd0);
    tbl[9]  = mk(0, 8'h00, 1, 0, 1, 0, 32'h0,        0, 0, 16'd0);
    tbl[10] = mk(1, 8'hAA, 1, 0, 1, 0, 32'h0,        0, 0, 16'd0);
    tbl[11] = mk(1, 8'hBB, 1, 0, 1, 0, 32'h0,        0, 0, 16'd1);
    tbl[12] = mk(1, 8'hCC, 1, 0, 1, 0, 32'h0,        0, 0, 16'd2);
    tbl[13] = mk(1, 8'hEE, 1, 1, 0, 0, 32'h0,        0, 0, 16'd3);
    tbl[14] = mk(1, 8'h11, 1, 0, 1, 0, 32'h0,        0, 0, 16'd0);
    tbl[15] = mk(1, 8'h12, 1, 0, 1, 0, 32'h0,        0, 0, 16'd1);
    tbl[16] = mk(1, 8'h13, 1, 0, 1, 0, 32'h0,        0, 0, 16'd2);
    tbl[17] = mk(1, 8'h14, 1, 0, 1, 0, 32'h0,        0, 0, 16'd3);
    tbl[18] = mk(0, 8'h00, 1, 0, 1, 1, 32'h14131211, 0, 0, 16'd4);
    tbl[19] = mk(0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 0, 16'd4);
    tbl[20] = mk(1, 8'h21, 0, 0, 1, 0, 32'h0,        0, 0, 16'd4);
    tbl[21] = mk(1, 8'h22, 0, 0, 1, 0, 32'h0,        0, 0, 16'd5);
    tbl[22] = mk(1, 8'h23, 0, 0, 1, 0, 32'h0,        0, 0, 16'd6);
    tbl[23] = mk(1, 8'h24, 0, 0, 1, 0, 32'h0,        0, 0, 16'd7);
    tbl[24] = mk(0, 8'h00, 0, 0, 1, 1, 32'h24232221, 1, 1, 16'd0);
    tbl[25] = mk(1, 8'h31, 0, 0, 1, 1, 32'h24232221, 1, 0, 16'd0);
    tbl[26] = mk(1, 8'h32, 0, 0, 1, 1, 32'h24232221, 1, 0, 16'd1);
    tbl[27] = mk(1, 8'h33, 0, 0, 1, 1, 32'h24232221, 1, 0, 16'd2);
    tbl[28] = mk(1, 8'h34, 1, 0, 1, 1, 32'h24232221, 1, 0, 16'd3);
    tbl[29] = mk(0, 8'h00, 0, 0, 1, 1, 32'h34333231, 0, 0, 16'd4);
    tbl[30] = mk(0, 8'h00, 1, 0, 1, 1, 32'h34333231, 0, 0, 16'd4);
    tbl[31] = mk(0, 8'h00, 0, 0, 1, 0, 32'h0,        0, 0, 16'd4);

    do_reset();

    // Frame packing, soft clear, and push/pop on the same edge.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_pix_valid  = tbl[i].v;
      a_pix_in     = tbl[i].pix;
      a_word_ready = tbl[i].wr;
      a_soft_clr   = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_pix_ready", i),  32'(a_pix_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_word_valid", i), 32'(a_word_valid), 32'(tbl[i].e_wv));
      if (tbl[i].e_wv) begin
        chk($sformatf("v%0d_word_out", i),  a_word_out,        tbl[i].e_wo);
        chk($sformatf("v%0d_word_last", i), 32'(a_word_last),  32'(tbl[i].e_wl));
      end
      chk($sformatf("v%0d_frame_done", i), 32'(a_frame_done), 32'(tbl[i].e_fd));
      chk($sformatf("v%0d_pix_count", i),  32'(a_pix_count),  32'(tbl[i].e_cnt));
    end

    // Reset mid-frame after 5 pixels, then a fresh frame from lane 0.
    do_reset();
    for (int i = 0; i < 5; i++) a_feed(8'(8'h51 + i), 1'b0);
    @(negedge clk);
    a_idle(1'b0);
    #1;
    chk("pre_rst_word_valid", 32'(a_word_valid), 32'd1);
    chk("pre_rst_pix_count",  32'(a_pix_count),  32'd5);
    do_reset();
    @(negedge clk);
    #1;
    chk("post_rst_pix_ready", 32'(a_pix_ready), 32'd1);
    chk("post_rst_word_valid", 32'(a_word_valid), 32'd0);
    for (int i = 0; i < 4; i++) a_feed(8'(8'h61 + i), 1'b1);
    @(negedge clk);
    a_idle(1'b1);
    #1;
    chk("post_rst_word_valid2", 32'(a_word_valid), 32'd1);
    chk("post_rst_word_out",    a_word_out,        32'h64636261);
    chk("post_rst_word_last",   32'(a_word_last),  32'd0);
    chk("post_rst_pix_count",   32'(a_pix_count),  32'd4);

    // Back-pressure with a two-entry FIFO, then drain.
    do_reset();
    next_idx = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      a_pix_valid  = (next_idx < 12);
      a_pix_in     = 8'(next_idx + 1);
      a_word_ready = (cyc >= 15);
      a_soft_clr   = 1'b0;
      #1;
      if (cyc == 8) begin
        chk("bp_accepted",  next_idx,          8);
        chk("bp_pix_ready", 32'(a_pix_ready),  32'd0);
      end
      if (cyc == 14) chk("bp_stall_count", next_idx, 8);
      if (a_pix_valid && a_pix_ready) next_idx++;
      if (a_word_valid && a_word_ready) got_q.push_back({a_word_last, a_word_out});
    end
    a_idle(1'b0);
    chk("bp_total_pixels", next_idx, 12);
    chk("bp_word_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp_word0", got_q[0][31:0], 32'h04030201);
      chk("bp_last0", 32'(got_q[0][32]), 32'd0);
      chk("bp_word1", got_q[1][31:0], 32'h08070605);
      chk("bp_last1", 32'(got_q[1][32]), 32'd1);
      chk("bp_word2", got_q[2][31:0], 32'h0C0B0A09);
      chk("bp_last2", 32'(got_q[2][32]), 32'd0);
    end

    // Six-pixel frame: short final word is zero-padded.
    got_q.delete();
    fd_cnt = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      b_pix_valid  = (cyc < 6);
      b_pix_in     = 8'(8'hA1 + cyc);
      b_word_ready = 1'b1;
      #1;
      if (cyc < 6) chk($sformatf("b_pix_ready%0d", cyc), 32'(b_pix_ready), 32'd1);
      if (b_frame_done) fd_cnt++;
      if (b_word_valid && b_word_ready) got_q.push_back({b_word_last, b_word_out});
    end
    b_pix_valid = 1'b0;
    chk("b_word_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b_word0", got_q[0][31:0], 32'hA4A3A2A1);
      chk("b_last0", 32'(got_q[0][32]), 32'd0);
      chk("b_word1", got_q[1][31:0], 32'h0000A6A5);
      chk("b_last1", 32'(got_q[1][32]), 32'd1);
    end
    chk("b_pix_count", 32'(b_pix_count), 32'd0);
    chk("b_frame_done_pulses", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 1024, pixels per frame (range 1..65535; need not be a multiple of 4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, word FIFO entries (power of 2, at least 2).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 pix_in  input  8  pixel byte from the upstream processing stage.
REQ-006 pix_valid  input  1  pix_in valid.
REQ-007 pix_ready  output  1  packer can accept a pixel.
REQ-008 soft_clr  input  1  synchronous clear of frame state and FIFO.
REQ-009 word_out  output  32  packed word at the FIFO head.
REQ-010 word_last  output  1  word_out is the final word of a frame.
REQ-011 word_valid  output  1  word_out/word_last valid.
REQ-012 word_ready  input  1  consumer accepts the word.
REQ-013 frame_done  output  1  single-cycle pulse at end of frame.
REQ-014 pix_count  output  16  pixels accepted in the current frame.

Function
REQ-015 A pixel SHALL be accepted on a rising edge only when pix_valid && pix_ready.
REQ-016 pix_ready SHALL equal !fifo_full, combinationally, with no same-cycle pass-through when the FIFO is full.
REQ-017 Byte lanes: the pixel accepted at lane k (k = 0..3) SHALL occupy word bits [8k+7:8k], with the first pixel in [7:0].
REQ-018 A 2-bit lane counter SHALL advance on each accept and wrap 3 -> 0.
REQ-019 On accepting a lane-3 pixel, the completed word SHALL be pushed into the FIFO on the same edge.
REQ-020 On accepting pixel number FRAME_PIXELS, the word SHALL be pushed with word_last=1, with unfilled upper lanes zero-padded.
REQ-021 At end of frame, the lane counter and pix_count SHALL return to 0 on the same edge.
REQ-022 frame_done SHALL pulse high for exactly one cycle, on the cycle after the final pixel is accepted.
REQ-023 The FIFO SHALL be 33 bits wide ({word_last, word}) and FIFO_DEPTH entries deep.
REQ-024 word_valid SHALL equal !fifo_empty.
REQ-025 word_out/word_last SHALL show the head entry combinationally.
REQ-026 The FIFO SHALL pop on word_valid && word_ready.
REQ-027 Latency: a word pushed at edge N SHALL be visible (word_valid=1) in the cycle after edge N when the FIFO was empty.
REQ-028 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 Occupancy SHALL be tracked with a counter of width clog2(FIFO_DEPTH)+1.
REQ-031 While word_valid=1 and word_ready=0, word_out/word_last SHALL hold stable.
REQ-032 soft_clr SHALL zero the lane counter, pix_count, the partial word and the FIFO pointers on the next edge, discarding any partial word.
REQ-033 Pixels presented while soft_clr=1 SHALL NOT be accepted; pix_ready SHALL be low while soft_clr=1.
REQ-034 frame_done SHALL NOT pulse because of soft_clr.

Reset
REQ-035 On rstn low, all outputs and state SHALL go low/zero immediately: pix_ready=0, word_valid=0, word_out=0, word_last=0, frame_done=0, pix_count=0, lane=0, FIFO empty.
REQ-036 pix_ready SHALL rise in the first cycle after rstn deasserts.
REQ-037 Reset mid-frame SHALL discard the partial word and all FIFO contents; the next accepted pixel SHALL be lane 0 of a new frame.

Structure
REQ-038 The FIFO SHALL be a separate sub-module pack_fifo (single-clock; parameters WIDTH, DEPTH; ports push, pop, full, empty).
REQ-039 The lane width (8), word width (32) and the last-flag bit position SHALL be constants in the shared pixel pipeline package.

Verification
REQ-040 Bench: FRAME_PIXELS=8, pixels 0x01..0x08, word_ready=1 -> words 0x04030201 (last=0) then 0x08070605 (last=1); frame_done pulses one cycle after 0x08 is accepted.
REQ-041 Bench: FRAME_PIXELS=6, pixels 0xA1..0xA6 -> second word 0x0000A6A5 with last=1; pix_count returns to 0.
REQ-042 Bench: FIFO_DEPTH=2, word_ready=0, stream 12 pixels -> pix_ready falls after pixel 8 is accepted; raising word_ready drains 0x..01 first and no pixel is lost or duplicated.
REQ-043 Bench: FIFO holds 1 entry, lane-3 accept and pop on the same edge -> occupancy stays 1.
REQ-044 Bench: soft_clr after 3 pixels, then 0x11..0x14 -> first word 0x14131211; frame_done never pulses for the aborted frame.
REQ-045 Bench: rstn low after 5 pixels -> word_valid=0 and pix_count=0 immediately; the following frame packs from lane 0.
